// File: rtl/instruction_fetch_if.sv
// Fetch-to-memory and fetch-to-decoder signal bundle for the tinycpu front end.
// The master side is the fetch stage; the slave side is its environment (memory, decoder, redirect source).
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  enable;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_do;
    logic                  DOR;
    logic                  ack_from_next;
    logic [31:0]           data_out;
    logic [31:0]           pc_out;
    logic                  pc_load;
    logic [31:0]           pc_load_value;

    modport master (
        input  enable, mem_do, ack_from_next, pc_load, pc_load_value,
        output mem_en, mem_addr, DOR, data_out, pc_out
    );

    modport slave (
        output enable, mem_do, ack_from_next, pc_load, pc_load_value,
        input  mem_en, mem_addr, DOR, data_out, pc_out
    );
endinterface

// File: rtl/instruction_fetch.sv
// tinycpu fetch stage: owns the PC, reads one word per fetch from synchronous
// instruction memory and holds it on DOR until the decoder acks or fetch is redirected.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 16
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);

    localparam logic [31:0] PC_INIT = RESET_PC & ~32'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_MEM = 2'd2,
        PRESENT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        dor_q, dor_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pc_out_q, pc_out_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= PC_INIT;
            dor_q    <= 1'b0;
            data_q   <= '0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            dor_q    <= dor_d;
            data_q   <= data_d;
            pc_out_q <= pc_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        dor_d    = dor_q;
        data_d   = data_q;
        pc_out_d = pc_out_q;

        case (state_q)
            IDLE: begin
                if (bus.enable) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                data_d   = bus.mem_do;
                pc_out_d = pc_q;
                dor_d    = 1'b1;
                state_d  = PRESENT;
            end
            PRESENT: begin
                if (bus.ack_from_next) begin
                    dor_d   = 1'b0;
                    pc_d    = pc_q + 32'd4;
                    state_d = bus.enable ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything, including a read whose data arrives this edge.
        if (bus.pc_load) begin
            pc_d     = bus.pc_load_value & ~32'd3;
            dor_d    = 1'b0;
            data_d   = data_q;
            pc_out_d = pc_out_q;
            state_d  = IDLE;
        end
    end

    assign bus.mem_en   = (state_q == ISSUE);
    assign bus.mem_addr = pc_q[ADDR_WIDTH+1:2];
    assign bus.DOR      = dor_q;
    assign bus.data_out = data_q;
    assign bus.pc_out   = pc_out_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a cycle-level reference of the fetch protocol checked every
// cycle on instance A, directed checks on A, and a second instance B for PC wrap and async reset.
module tb_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    instruction_fetch_if #(.ADDR_WIDTH(16)) bus_a ();
    instruction_fetch_if #(.ADDR_WIDTH(16)) bus_b ();

    instruction_fetch #(.RESET_PC(32'h0000_0100), .ADDR_WIDTH(16)) dut_a (
        .clk  (clk),
        .reset(rst_a),
        .bus  (bus_a)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .ADDR_WIDTH(16)) dut_b (
        .clk  (clk),
        .reset(rst_b),
        .bus  (bus_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    logic [31:0] mem_ovr [int unsigned];

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (mem_ovr.exists(32'(a))) return mem_ovr[32'(a)];
        return {~a, a};
    endfunction

    // Synchronous memories; data is garbage on cycles without a read so a late sample shows up.
    always @(posedge clk) bus_a.mem_do <= bus_a.mem_en ? mem_word(bus_a.mem_addr) : $urandom;
    always @(posedge clk) bus_b.mem_do <= bus_b.mem_en ? mem_word(bus_b.mem_addr) : $urandom;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference for instance A: where the current fetch is in its life.
    logic [31:0] m_pc, m_data, m_pcout;
    logic        m_dor;
    int          m_phase;
    logic [15:0] m_iaddr;

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            m_pc    <= 32'h0000_0100;
            m_dor   <= 1'b0;
            m_data  <= 32'h0;
            m_pcout <= 32'h0;
            m_phase <= 0;
            m_iaddr <= 16'h0;
        end else if (bus_a.pc_load) begin
            m_pc    <= {bus_a.pc_load_value[31:2], 2'b00};
            m_dor   <= 1'b0;
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (bus_a.enable) m_phase <= 1;
                1: begin
                    m_iaddr <= m_pc[17:2];
                    m_phase <= 2;
                end
                2: begin
                    m_data  <= mem_word(m_iaddr);
                    m_pcout <= m_pc;
                    m_dor   <= 1'b1;
                    m_phase <= 3;
                end
                default: if (bus_a.ack_from_next) begin
                    m_dor   <= 1'b0;
                    m_pc    <= m_pc + 32'd4;
                    m_phase <= bus_a.enable ? 1 : 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model DOR",      32'(bus_a.DOR),      32'(m_dor));
            chk("model mem_en",   32'(bus_a.mem_en),   32'(m_phase == 1));
            chk("model mem_addr", 32'(bus_a.mem_addr), 32'(m_pc[17:2]));
            chk("model data_out", bus_a.data_out,      m_data);
            chk("model pc_out",   bus_a.pc_out,        m_pcout);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dor_a();
        int k = 0;
        while (bus_a.DOR !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("A DOR wait", 32'(bus_a.DOR), 32'd1);
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.enable = 1'b1; bus_a.ack_from_next = 1'b0; bus_a.pc_load = 1'b0; bus_a.pc_load_value = '0;
        bus_b.enable = 1'b1; bus_b.ack_from_next = 1'b0; bus_b.pc_load = 1'b0; bus_b.pc_load_value = '0;
        mem_ovr[32'h40] = 32'h2402_0005;
        for (int i = 0; i < 4; i++) mem_ovr[i] = 32'hA0 + 32'(i);

        repeat (3) @(posedge clk);
        cmp_on = 1'b1;
        #1;
        rst_a = 1'b1;

        // Reset state and first fetch from RESET_PC
        chk("rst DOR",      32'(bus_a.DOR),      32'd0);
        chk("rst mem_en",   32'(bus_a.mem_en),   32'd0);
        chk("rst mem_addr", 32'(bus_a.mem_addr), 32'h40);
        chk("rst data_out", bus_a.data_out,      32'h0);
        chk("rst pc_out",   bus_a.pc_out,        32'h0);
        step();
        chk("c1 mem_en",   32'(bus_a.mem_en),   32'd1);
        chk("c1 mem_addr", 32'(bus_a.mem_addr), 32'h40);
        step();
        chk("c2 mem_en", 32'(bus_a.mem_en), 32'd0);
        chk("c2 DOR",    32'(bus_a.DOR),    32'd0);
        step();
        chk("c3 DOR",      32'(bus_a.DOR), 32'd1);
        chk("c3 data_out", bus_a.data_out, 32'h2402_0005);
        chk("c3 pc_out",   bus_a.pc_out,   32'h100);

        // Hold without ack
        repeat (10) begin
            step();
            chk("hold DOR",      32'(bus_a.DOR),    32'd1);
            chk("hold data_out", bus_a.data_out,    32'h2402_0005);
            chk("hold pc_out",   bus_a.pc_out,      32'h100);
            chk("hold mem_en",   32'(bus_a.mem_en), 32'd0);
        end
        bus_a.ack_from_next = 1'b1;
        step();
        bus_a.ack_from_next = 1'b0;
        chk("ack DOR",      32'(bus_a.DOR),      32'd0);
        chk("ack mem_en",   32'(bus_a.mem_en),   32'd1);
        chk("ack mem_addr", 32'(bus_a.mem_addr), 32'h41);

        // Sequence from address 0
        bus_a.pc_load = 1'b1; bus_a.pc_load_value = 32'h0;
        step();
        bus_a.pc_load = 1'b0;
        chk("seq load DOR", 32'(bus_a.DOR), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_dor_a();
            chk("seq data_out", bus_a.data_out, 32'hA0 + 32'(i));
            chk("seq pc_out",   bus_a.pc_out,   32'(4 * i));
            step();
            chk("seq DOR held", 32'(bus_a.DOR), 32'd1);
            bus_a.ack_from_next = 1'b1;
            step();
            bus_a.ack_from_next = 1'b0;
            chk("seq DOR drop", 32'(bus_a.DOR), 32'd0);
        end

        // Redirect colliding with ack
        bus_a.pc_load = 1'b1; bus_a.pc_load_value = 32'h8;
        step();
        bus_a.pc_load = 1'b0;
        wait_dor_a();
        chk("col pre pc_out", bus_a.pc_out,   32'h8);
        chk("col pre data",   bus_a.data_out, 32'hA2);
        bus_a.pc_load = 1'b1; bus_a.pc_load_value = 32'h203; bus_a.ack_from_next = 1'b1;
        step();
        bus_a.pc_load = 1'b0; bus_a.ack_from_next = 1'b0;
        chk("col DOR",      32'(bus_a.DOR),      32'd0);
        chk("col pc_out",   bus_a.pc_out,        32'h8);
        chk("col mem_addr", 32'(bus_a.mem_addr), 32'h80);
        step();
        chk("col issue mem_en",   32'(bus_a.mem_en),   32'd1);
        chk("col issue mem_addr", 32'(bus_a.mem_addr), 32'h80);
        wait_dor_a();
        chk("col pc_out next", bus_a.pc_out,   32'h200);
        chk("col data next",   bus_a.data_out, mem_word(16'h80));

        // Redirect while a read is in flight
        step();
        bus_a.ack_from_next = 1'b1;
        step();
        bus_a.ack_from_next = 1'b0;
        step();
        chk("fly in WAIT_MEM", 32'(bus_a.mem_en), 32'd0);
        bus_a.pc_load = 1'b1; bus_a.pc_load_value = 32'h40;
        step();
        bus_a.pc_load = 1'b0;
        chk("fly DOR",    32'(bus_a.DOR), 32'd0);
        chk("fly pc_out", bus_a.pc_out,   32'h200);
        wait_dor_a();
        chk("fly pc_out next", bus_a.pc_out,   32'h40);
        chk("fly data next",   bus_a.data_out, mem_word(16'h10));

        // Randomized traffic against the reference, with one async reset pulse
        for (int i = 0; i < 3000; i++) begin
            bus_a.enable        = ($urandom_range(0, 9) != 0);
            bus_a.ack_from_next = ($urandom_range(0, 2) == 0);
            bus_a.pc_load       = ($urandom_range(0, 39) == 0);
            bus_a.pc_load_value = $urandom;
            if (i == 1500) begin
                #2 rst_a = 1'b0;
                #1 rst_a = 1'b1;
            end
            step();
        end
        bus_a.ack_from_next = 1'b0;
        bus_a.pc_load = 1'b0;

        // Instance B: PC wrap and asynchronous reset
        rst_b = 1'b1;
        chk("B rst mem_addr", 32'(bus_b.mem_addr), 32'hFFFF);
        chk("B rst DOR",      32'(bus_b.DOR),      32'd0);
        repeat (3) step();
        chk("B DOR",      32'(bus_b.DOR), 32'd1);
        chk("B pc_out",   bus_b.pc_out,   32'hFFFF_FFFC);
        chk("B data_out", bus_b.data_out, 32'h0000_FFFF);
        step();
        bus_b.ack_from_next = 1'b1;
        step();
        bus_b.ack_from_next = 1'b0;
        chk("B wrap DOR",      32'(bus_b.DOR),      32'd0);
        chk("B wrap mem_en",   32'(bus_b.mem_en),   32'd1);
        chk("B wrap mem_addr", 32'(bus_b.mem_addr), 32'h0);
        repeat (2) step();
        chk("B wrap pc_out", bus_b.pc_out,   32'h0);
        chk("B wrap data",   bus_b.data_out, 32'hA0);
        step();
        bus_b.ack_from_next = 1'b1;
        step();
        bus_b.ack_from_next = 1'b0;
        chk("B issue mem_en", 32'(bus_b.mem_en), 32'd1);
        step();
        #2 rst_b = 1'b0;
        #1;
        chk("B arst DOR",      32'(bus_b.DOR),      32'd0);
        chk("B arst mem_en",   32'(bus_b.mem_en),   32'd0);
        chk("B arst mem_addr", 32'(bus_b.mem_addr), 32'hFFFF);
        chk("B arst pc_out",   bus_b.pc_out,        32'h0);
        chk("B arst data_out", bus_b.data_out,      32'h0);
        step();
        rst_b = 1'b1;
        step();
        chk("B refetch mem_en",   32'(bus_b.mem_en),   32'd1);
        chk("B refetch mem_addr", 32'(bus_b.mem_addr), 32'hFFFF);
        repeat (2) step();
        chk("B refetch DOR",    32'(bus_b.DOR), 32'd1);
        chk("B refetch pc_out", bus_b.pc_out,   32'hFFFF_FFFC);
        #2 rst_b = 1'b0;
        #1;
        chk("B arst PRESENT DOR", 32'(bus_b.DOR), 32'd0);
        rst_b = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
